alu: RTL and testbench



---
 rtl/alu.sv | 175 +++++++++++++++++
 tb/tb_alu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 32-bit MIPS-style ALU: add/sub, logic, LUI, set-less-than, shifts, plus Z/C/N/V flags.
// Latency: 1 cycle, result and flags update together on every rising clk edge.
// Backpressure: none; a new operation is accepted every cycle (no enable, no handshake).
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (result=0, zero=1, other flags 0)
//   a        - operand A; a[4:0] is the shift amount for shift ops
//   b        - operand B; the value being shifted for shift ops
//   aluc     - 4-bit operation select
//   result   - registered 32-bit result
//   zero     - registered zero flag (a==b for SLT/SLTU, else result==0)
//   carry    - registered carry / borrow / last-shifted-out bit
//   negative - registered negative flag
//   overflow - registered signed-overflow flag (ADD/SUB only)
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry,
  output logic        negative,
  output logic        overflow
);

  localparam logic [3:0] OP_ADDU = 4'b0000;
  localparam logic [3:0] OP_SUBU = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_LUI0 = 4'b1000;
  localparam logic [3:0] OP_LUI1 = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SLL0 = 4'b1110;
  localparam logic [3:0] OP_SLL1 = 4'b1111;

  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic [4:0]  w_shamt;
  logic [4:0]  w_sr_idx;
  logic [4:0]  w_sl_idx;
  logic [31:0] w_sra;
  logic        w_ltu;
  logic        w_lts;
  logic        w_eq;
  logic        w_sr_out;
  logic        w_sl_out;

  logic [31:0] w_nxt_res;
  logic        w_nxt_zero;
  logic        w_nxt_carry;
  logic        w_nxt_neg;
  logic        w_nxt_ovf;

  logic [31:0] r_result;
  logic        r_zero;
  logic        r_carry;
  logic        r_negative;
  logic        r_overflow;

  // 33-bit add/sub so bit 32 is the unsigned carry-out / borrow directly.
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_shamt = a[4:0];
  assign w_sra   = $signed(b) >>> w_shamt;
  assign w_ltu   = w_diff[32];
  assign w_lts   = $signed(a) < $signed(b);
  assign w_eq    = (a == b);

  // Last bit shifted out. Right shifts lose b[shamt-1]; left shifts lose
  // b[32-shamt], which modulo 32 is simply -shamt. Both are masked to 0
  // when shamt is 0 because nothing is shifted out then.
  assign w_sr_idx = w_shamt - 5'd1;
  assign w_sl_idx = 5'd0 - w_shamt;
  assign w_sr_out = (w_shamt != 5'd0) && b[w_sr_idx];
  assign w_sl_out = (w_shamt != 5'd0) && b[w_sl_idx];

  always_comb begin
    w_nxt_res   = '0;
    w_nxt_carry = 1'b0;
    w_nxt_ovf   = 1'b0;
    case (aluc)
      OP_ADDU: begin
        w_nxt_res   = w_sum[31:0];
        w_nxt_carry = w_sum[32];
      end
      OP_ADD: begin
        w_nxt_res   = w_sum[31:0];
        w_nxt_carry = w_sum[32];
        w_nxt_ovf   = (a[31] == b[31]) && (w_sum[31] != a[31]);
      end
      OP_SUBU: begin
        w_nxt_res   = w_diff[31:0];
        w_nxt_carry = w_ltu;
      end
      OP_SUB: begin
        w_nxt_res   = w_diff[31:0];
        w_nxt_carry = w_ltu;
        w_nxt_ovf   = (a[31] != b[31]) && (w_diff[31] != a[31]);
      end
      OP_AND:  w_nxt_res = a & b;
      OP_OR:   w_nxt_res = a | b;
      OP_XOR:  w_nxt_res = a ^ b;
      OP_NOR:  w_nxt_res = ~(a | b);
      OP_LUI0, OP_LUI1: w_nxt_res = {b[15:0], 16'h0000};
      OP_SLTU: begin
        w_nxt_res   = {31'd0, w_ltu};
        w_nxt_carry = w_ltu;
      end
      OP_SLT:  w_nxt_res = {31'd0, w_lts};
      OP_SRA: begin
        w_nxt_res   = w_sra;
        w_nxt_carry = w_sr_out;
      end
      OP_SRL: begin
        w_nxt_res   = b >> w_shamt;
        w_nxt_carry = w_sr_out;
      end
      OP_SLL0, OP_SLL1: begin
        w_nxt_res   = b << w_shamt;
        w_nxt_carry = w_sl_out;
      end
      default: begin
        w_nxt_res   = '0;
        w_nxt_carry = 1'b0;
        w_nxt_ovf   = 1'b0;
      end
    endcase
  end

  // Comparisons report equality on zero (usable for beq-style decisions)
  // rather than the 0/1 result; SLT reports its outcome on negative.
  always_comb begin
    w_nxt_zero = (w_nxt_res == 32'd0);
    w_nxt_neg  = w_nxt_res[31];
    if ((aluc == OP_SLT) || (aluc == OP_SLTU)) begin
      w_nxt_zero = w_eq;
    end
    if (aluc == OP_SLT) begin
      w_nxt_neg = w_lts;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_carry    <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_nxt_res;
      r_zero     <= w_nxt_zero;
      r_carry    <= w_nxt_carry;
      r_negative <= w_nxt_neg;
      r_overflow <= w_nxt_ovf;
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign negative = r_negative;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        negative;
  logic        overflow;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .aluc     (aluc),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input vec_t e);
    chk({e.name, ".result"},   result,            e.res);
    chk({e.name, ".zero"},     {31'd0, zero},     {31'd0, e.z});
    chk({e.name, ".carry"},    {31'd0, carry},    {31'd0, e.c});
    chk({e.name, ".negative"}, {31'd0, negative}, {31'd0, e.n});
    chk({e.name, ".overflow"}, {31'd0, overflow}, {31'd0, e.v});
  endtask

  function automatic vec_t mk(string nm, logic [3:0] op, logic [31:0] va, logic [31:0] vb,
                              logic [31:0] r, logic z, logic c, logic n, logic v);
    vec_t t;
    t.name = nm; t.op = op; t.a = va; t.b = vb;
    t.res = r; t.z = z; t.c = c; t.n = n; t.v = v;
    return t;
  endfunction

  // Monitor: one registered result appears after every rising edge.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all(e);
      end
    end
  end

  initial begin
    vec_t rst_exp;
    vec_t e;
    // Hand-computed vectors:          op       a             b             result        z     c     n     v
    vecs.push_back(mk("addu_wrap",    4'b0000, 32'hffffffff, 32'h80000000, 32'h7fffffff, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("add_negovf",   4'b0010, 32'hffffffff, 32'h80000000, 32'h7fffffff, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk("and_msb",      4'b0100, 32'hffffffff, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk("add_posovf",   4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("sub_noovf",    4'b0011, 32'h7fffffff, 32'h00000001, 32'h7ffffffe, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("subu_borrow",  4'b0001, 32'h00000000, 32'h00000001, 32'hffffffff, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk("sub_borrow",   4'b0011, 32'h00000000, 32'h00000001, 32'hffffffff, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk("nor",          4'b0111, 32'h00000000, 32'h00000001, 32'hfffffffe, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk("lui_1000",     4'b1000, 32'h00000000, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("lui_1001_z",   4'b1001, 32'h00000000, 32'hffff0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("slt_false",    4'b1011, 32'h00000020, 32'hffffffc0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("sltu_true",    4'b1010, 32'h00000020, 32'hffffffc0, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("sra_16",       4'b1100, 32'h00000010, 32'h80000000, 32'hffff8000, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk("srl_16",       4'b1101, 32'h00000010, 32'h80000000, 32'h00008000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("sll_16_zero",  4'b1110, 32'h00000010, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("srl_8_cout",   4'b1101, 32'h00000008, 32'hffffffff, 32'h00ffffff, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("or_zero",      4'b0101, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("xor",          4'b0110, 32'ha5a5a5a5, 32'hffffffff, 32'h5a5a5a5a, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("slt_true",     4'b1011, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk("sltu_equal",   4'b1010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("sll_1111_cout",4'b1111, 32'h00000001, 32'h80000001, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("sra_0",        4'b1100, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk("sub_ovf",      4'b0011, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("addu_zero",    4'b0000, 32'h00000001, 32'hffffffff, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("sra_4_cout",   4'b1100, 32'h00000004, 32'h8000000f, 32'hf8000000, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk("sll_0",        4'b1110, 32'h00000000, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0));

    rst_exp = mk("reset", 4'b0000, 32'h0, 32'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held through the first edge.
    rst_n = 1'b0;
    a     = 32'h12345678;
    b     = 32'h9abcdef0;
    aluc  = 4'b0000;
    @(negedge clk);
    chk_all(rst_exp);

    // Back-to-back directed vectors, one per cycle.
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      a    = vecs[i].a;
      b    = vecs[i].b;
      aluc = vecs[i].op;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
    end

    // Mid-operation asynchronous reset: pending ADD must be discarded.
    a    = 32'h7fffffff;
    b    = 32'h00000001;
    aluc = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    rst_exp.name = "async_reset";
    chk_all(rst_exp);
    @(posedge clk);
    #1;
    rst_exp.name = "reset_held";
    chk_all(rst_exp);

    // Release: the next edge captures the current inputs.
    @(negedge clk);
    rst_n = 1'b1;
    e = mk("after_release", 4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(e);
    @(negedge clk);
    @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
